// File: rtl/trig_tx_framer.sv
// trig_tx_framer: buffers 32-bit trigger words and emits fixed-length
// header/payload/XOR-trailer frames towards a single-lane Aurora TX port.
`default_nettype none

module trig_tx_framer #(
  parameter int          FIFO_AW      = 4,
  parameter int          FRAME_LEN    = 4,
  parameter logic [15:0] HEADER_MAGIC = 16'hB0CA
) (
  input  logic             user_clk,
  input  logic             reset,
  input  logic             channel_up,
  input  logic [31:0]      in_d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      tx_d,
  output logic             tx_src_rdy_n,
  input  logic             tx_dst_rdy_n,
  output logic [FIFO_AW:0] fifo_level,
  output logic [15:0]      frame_count,
  output logic             overflow,
  output logic             frame_abort
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LEN_L   = (FIFO_AW+1)'(FRAME_LEN);
  localparam logic [FIFO_AW:0] LAST_L  = (FIFO_AW+1)'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  state_t             state;
  logic [15:0]        seq;
  logic [31:0]        csum;
  logic [FIFO_AW:0]   cnt;
  logic               accept;
  logic               wr;
  logic               pop;

  assign in_ready   = (level < DEPTH_L);
  assign fifo_level = level;
  assign wr         = in_valid && in_ready;
  // A transfer is honoured only while the channel is up; a drop wins over a same-cycle accept.
  assign accept     = !tx_src_rdy_n && !tx_dst_rdy_n && channel_up;
  assign pop        = accept && (state == S_PAYLOAD);

  always_ff @(posedge user_clk) begin
    if (wr) begin
      mem[wr_ptr] <= in_d;
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      state       <= S_IDLE;
      seq         <= '0;
      csum        <= '0;
      cnt         <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !wr) begin
        level <= level - 1'b1;
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (channel_up && (level >= LEN_L)) begin
            state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!channel_up) begin
            state       <= S_IDLE;
            frame_abort <= 1'b1;
          end else if (accept) begin
            csum  <= '0;
            cnt   <= '0;
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!channel_up) begin
            state       <= S_IDLE;
            frame_abort <= 1'b1;
          end else if (accept) begin
            csum <= csum ^ mem[rd_ptr];
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_L) begin
              state <= S_TRAILER;
            end
          end
        end
        S_TRAILER: begin
          if (!channel_up) begin
            state       <= S_IDLE;
            frame_abort <= 1'b1;
          end else if (accept) begin
            seq         <= seq + 1'b1;
            frame_count <= frame_count + 1'b1;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Stream outputs depend only on registered state and the stored FIFO head.
  always_comb begin
    tx_d         = '0;
    tx_src_rdy_n = (state == S_IDLE);
    case (state)
      S_HEADER:  tx_d = {HEADER_MAGIC, seq};
      S_PAYLOAD: tx_d = mem[rd_ptr];
      S_TRAILER: tx_d = csum;
      default:   tx_d = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trig_tx_framer.sv
// tb_trig_tx_framer: directed test-plan scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based frame model.
`default_nettype none

module tb_trig_tx_framer;

  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cu = 1'b0;
  logic [31:0] id = '0;
  logic        iv = 1'b0;
  logic        dr_n = 1'b1;
  logic        in_ready;
  logic [31:0] tx_d;
  logic        tx_src_rdy_n;
  logic [4:0]  fifo_level;
  logic [15:0] frame_count;
  logic        overflow;
  logic        frame_abort;

  int checks = 0;
  int errors = 0;

  trig_tx_framer #(.FIFO_AW(4), .FRAME_LEN(N), .HEADER_MAGIC(16'hB0CA)) dut (
    .user_clk     (clk),
    .reset        (rst),
    .channel_up   (cu),
    .in_d         (id),
    .in_valid     (iv),
    .in_ready     (in_ready),
    .tx_d         (tx_d),
    .tx_src_rdy_n (tx_src_rdy_n),
    .tx_dst_rdy_n (dr_n),
    .fifo_level   (fifo_level),
    .frame_count  (frame_count),
    .overflow     (overflow),
    .frame_abort  (frame_abort)
  );

  always #5 clk = ~clk;

  // Model: buffered words, position within the frame (-1 idle, 0 header,
  // 1..N payload slot, N+1 trailer) and the payload words sent so far.
  logic [31:0] mq[$];
  logic [31:0] sent[$];
  int          m_phase = -1;
  logic [15:0] m_seq = '0;
  logic [15:0] m_fc = '0;
  bit          m_ovf = 0;
  bit          m_abort = 0;

  logic [31:0] acc_log[$];

  always @(posedge clk) begin
    if (!rst && cu && !tx_src_rdy_n && !dr_n) acc_log.push_back(tx_d);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_tx();
    logic [31:0] x = '0;
    if (m_phase < 0) return '0;
    if (m_phase == 0) return {16'hB0CA, m_seq};
    if (m_phase <= N) return (mq.size() > 0) ? mq[0] : 32'hDEAD_BEEF;
    foreach (sent[k]) x ^= sent[k];
    return x;
  endfunction

  task automatic model_edge();
    int sz = mq.size();
    bit acc;
    if (rst) begin
      mq.delete(); sent.delete();
      m_phase = -1; m_seq = '0; m_fc = '0; m_ovf = 0; m_abort = 0;
      return;
    end
    acc     = (m_phase >= 0) && !dr_n && cu;
    m_abort = (m_phase >= 0) && !cu;
    if (iv && sz >= DEPTH) m_ovf = 1;
    if (m_phase < 0) begin
      if (cu && sz >= N) m_phase = 0;
    end else if (!cu) begin
      m_phase = -1;
    end else if (acc) begin
      if (m_phase == 0) begin
        sent.delete();
        m_phase = 1;
      end else if (m_phase <= N) begin
        sent.push_back(mq.pop_front());
        m_phase++;
      end else begin
        m_seq++;
        m_fc++;
        m_phase = -1;
      end
    end
    if (iv && sz < DEPTH) mq.push_back(id);
  endtask

  task automatic compare();
    chk("src_rdy_n", 32'(tx_src_rdy_n), 32'(m_phase < 0));
    chk("tx_d", tx_d, exp_tx());
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_abort", 32'(frame_abort), 32'(m_abort));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic put(input logic [31:0] w);
    iv = 1'b1; id = w;
    step();
    iv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; iv = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    int n = 0;
    while (m_phase != target && n < 60) begin
      step();
      n++;
    end
    if (m_phase != target) chk("wait_phase_timeout", 32'(m_phase), 32'(target));
  endtask

  task automatic check_log(input string tag, input logic [31:0] exp[$]);
    chk({tag, "_len"}, 32'(acc_log.size()), 32'(exp.size()));
    foreach (exp[k]) begin
      if (k < acc_log.size()) chk(tag, acc_log[k], exp[k]);
    end
  endtask

  initial begin
    logic [31:0] exp[$];
    logic [31:0] x;

    do_reset();
    chk("reset_src_rdy_n", 32'(tx_src_rdy_n), 32'd1);
    chk("reset_level", 32'(fifo_level), 32'd0);

    // Basic frame
    cu = 1'b1; dr_n = 1'b0; acc_log.delete();
    for (int i = 1; i <= 4; i++) put(32'(i));
    repeat (8) step();
    exp = '{32'hB0CA0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'h00000004};
    check_log("basic", exp);
    chk("basic_frame_count", 32'(frame_count), 32'd1);

    // Short fill, then back-pressure on payload word 2
    acc_log.delete();
    for (int i = 11; i <= 13; i++) put(32'(i));
    repeat (3) step();
    chk("short_idle", 32'(tx_src_rdy_n), 32'd1);
    put(32'd14);
    chk("short_t1_idle", 32'(tx_src_rdy_n), 32'd1);
    step();
    chk("short_hdr_valid", 32'(tx_src_rdy_n), 32'd0);
    chk("short_hdr", tx_d, 32'hB0CA0001);
    wait_phase(2);
    dr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", tx_d, 32'd12);
    end
    dr_n = 1'b0;
    repeat (8) step();
    exp = '{32'hB0CA0001, 32'd11, 32'd12, 32'd13, 32'd14, 32'd11 ^ 32'd12 ^ 32'd13 ^ 32'd14};
    check_log("bp", exp);

    // Overflow with channel down, then drain as four frames
    do_reset();
    cu = 1'b0;
    for (int i = 0; i < 16; i++) put(32'(100 + i));
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    put(32'd999);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    acc_log.delete();
    cu = 1'b1; dr_n = 1'b0;
    repeat (32) step();
    exp.delete();
    for (int f = 0; f < 4; f++) begin
      exp.push_back({16'hB0CA, 16'(f)});
      x = '0;
      for (int k = 0; k < 4; k++) begin
        exp.push_back(32'(100 + 4*f + k));
        x ^= 32'(100 + 4*f + k);
      end
      exp.push_back(x);
    end
    check_log("ovf_drain", exp);

    // Abort after header and one payload accept
    do_reset();
    cu = 1'b1; dr_n = 1'b0;
    for (int i = 0; i < 4; i++) put(32'(200 + i));
    wait_phase(2);
    cu = 1'b0;
    step();
    chk("abort_src", 32'(tx_src_rdy_n), 32'd1);
    chk("abort_pulse", 32'(frame_abort), 32'd1);
    chk("abort_level", 32'(fifo_level), 32'd3);
    chk("abort_fc", 32'(frame_count), 32'd0);
    step();
    chk("abort_pulse_end", 32'(frame_abort), 32'd0);
    put(32'd204);
    acc_log.delete();
    cu = 1'b1;
    repeat (10) step();
    exp = '{32'hB0CA0000, 32'd201, 32'd202, 32'd203, 32'd204, 32'd201 ^ 32'd202 ^ 32'd203 ^ 32'd204};
    check_log("abort_resume", exp);

    // Reset mid-frame
    for (int i = 0; i < 4; i++) put(32'(300 + i));
    wait_phase(2);
    rst = 1'b1;
    step();
    chk("rst_mid_src", 32'(tx_src_rdy_n), 32'd1);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    chk("rst_mid_txd", tx_d, 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      iv   = ($urandom_range(0, 99) < 45);
      id   = $urandom;
      cu   = ($urandom_range(0, 99) < 97);
      dr_n = ($urandom_range(0, 99) < 30);
      rst  = ($urandom_range(0, 999) < 2);
      step();
    end
    rst = 1'b0; iv = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trig_tx_framer.md
# trig_tx_framer

Packetising stage that sits directly upstream of the single-lane Aurora TX streaming interface in the trigger-consolidation design. It buffers 32-bit trigger words in a small FIFO and emits fixed-length frames on `tx_d`/`tx_src_rdy_n`: header, payload, XOR trailer. It honours `tx_dst_rdy_n` back-pressure and holds transmission while `channel_up` is low. The block runs entirely in the Aurora `user_clk` domain.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW words.
- `FRAME_LEN`, 4: payload words per frame; legal range 1 .. 2^FIFO_AW.
- `HEADER_MAGIC`, 16'hB0CA: upper 16 bits of every header word.
- `user_clk`, input, 1: sole clock (Aurora user clock).
- `reset`, input, 1: synchronous, active-high reset.
- `channel_up`, input, 1: Aurora channel status; frames are sent only while this is high.
- `in_d`, input, 32: trigger word to enqueue.
- `in_valid`, input, 1: `in_d` is valid this cycle.
- `in_ready`, output, 1: FIFO not full; high means a write is accepted.
- `tx_d`, output, 32: stream word to the Aurora TX port.
- `tx_src_rdy_n`, output, 1: active-low word valid.
- `tx_dst_rdy_n`, input, 1: active-low Aurora ready.
- `fifo_level`, output, FIFO_AW+1: current FIFO occupancy.
- `frame_count`, output, 16: frames completed since reset; wraps.
- `overflow`, output, 1: sticky flag; a word was offered while the FIFO was full.
- `frame_abort`, output, 1: one-cycle pulse when a frame is abandoned because `channel_up` fell.

## Operation
- **Reset values:** `tx_src_rdy_n`=1, `tx_d`=0, `in_ready`=1, `fifo_level`=0, `frame_count`=0, `overflow`=0, `frame_abort`=0, sequence counter `seq`=0, checksum=0, FSM=IDLE, FIFO pointers cleared.
- **Transfer rule:** a word moves only in a cycle where `tx_src_rdy_n`=0 and `tx_dst_rdy_n`=0 ("accept").
- **FIFO write:**
  - `in_ready` = level < 2^FIFO_AW, computed from the registered level.
  - A write occurs when `in_valid` && `in_ready`.
  - `in_valid` && !`in_ready` drops the word and sets `overflow`.
- **FIFO read:** first-word-fall-through; the head word is visible without a read strobe. It is popped on a PAYLOAD accept.
- **Level update:** a simultaneous write and pop leaves the level unchanged. At full, a write is refused even if a pop occurs in the same cycle.
- **FSM:**
  - IDLE: `tx_src_rdy_n`=1, `tx_d`=0. Go to HEADER when `channel_up` && `fifo_level` >= FRAME_LEN.
  - HEADER: `tx_d` = {HEADER_MAGIC, seq}. On accept, clear the checksum and the payload counter, then go to PAYLOAD.
  - PAYLOAD: `tx_d` = FIFO head. On accept: pop, checksum ^= word, counter++. The accept with counter == FRAME_LEN-1 moves to TRAILER.
  - TRAILER: `tx_d` = checksum (XOR of the payload words only). On accept: seq++, `frame_count`++, go to IDLE.
- **Payload never starves:** a frame starts only when FRAME_LEN words are buffered, so `tx_src_rdy_n` stays low from header to trailer unless the frame is aborted.
- **Abort:** `channel_up`=0 in HEADER, PAYLOAD or TRAILER forces IDLE on the next edge and pulses `frame_abort`.
  - Payload words already popped are lost.
  - seq and `frame_count` are not incremented.
  - Remaining FIFO contents are retained.
  - The next frame reuses the same seq.
- **Wrap-around:** seq, `frame_count` and the FIFO pointers wrap modulo their widths with no side effects.
- **Reset mid-frame:** all state returns to the reset values on the next edge and the FIFO is emptied.

## Timing
- `tx_d` and `tx_src_rdy_n` are decoded from registered state and the registered FIFO head. There is no combinational path from `tx_dst_rdy_n` to `tx_d` or `tx_src_rdy_n`.
- While `tx_src_rdy_n`=0 and `tx_dst_rdy_n`=1, `tx_d` is held stable with no loss or duplication.
- **Latency:** a write completing FRAME_LEN buffered words in cycle t is reflected in `fifo_level` at t+1. The header is presented at t+2 when `channel_up`=1.
- **Throughput:** with `tx_dst_rdy_n` held at 0, a frame occupies FRAME_LEN+2 consecutive cycles. Each trailer is followed by one IDLE cycle before the next header.
- `in_ready` and `fifo_level` update one cycle after the write or pop that changes them.

## Test plan
- **Basic frame:** reset, `channel_up`=1, `tx_dst_rdy_n`=0, write 1,2,3,4. Expect B0CA0000, 1, 2, 3, 4, 00000004 on consecutive cycles, then `frame_count`=1.
- **Back-pressure:** hold `tx_dst_rdy_n`=1 for 3 cycles while word 2 is presented. Expect `tx_d`=2 held stable; the full sequence is still header, 1, 2, 3, 4, trailer, with nothing duplicated.
- **Short fill:** write 3 words; `tx_src_rdy_n` stays 1. Write a 4th; the header appears 2 cycles later carrying seq 1 (B0CA0001).
- **Overflow:** with `channel_up`=0, write 17 words.
  - Expect 16 accepted, `in_ready`=0 after the 16th, the 17th dropped, `overflow`=1.
  - Raise `channel_up`; expect 4 frames with seq 0..3, each separated by one IDLE cycle.
- **Abort:** drop `channel_up` after the header and one payload accept.
  - Expect `tx_src_rdy_n`=1 next cycle, a one-cycle `frame_abort` pulse, `fifo_level`=3, `frame_count` unchanged.
  - Write one more word and restore `channel_up`; the next header carries the same seq.
- **Reset mid-frame:** assert `reset` during PAYLOAD. Next cycle all outputs are at reset values and `fifo_level`=0.
